ula_mul_seq: RTL and testbench

- Multi-cycle controller that reuses the existing 16-bit ula to perform unsigned shift-and-add multiplication.
- Instantiates one ula and drives its op, A and B inputs from a small FSM, one ula operation per cycle.
- Sits beside the main control unit; the control unit pulses start, waits for done, then reads product (low 16 bits) into the register file.

---
 rtl/ula_pkg.sv | 20 ++
 rtl/ula.sv | 27 ++
 rtl/ula_mul_seq.sv | 133 +++++++++++++
 tb/tb_ula_mul_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the 16-bit ula and the sequential multiplier that drives it:
// ula op codes and the multiplier FSM state encoding.
package ula_pkg;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_OR  = 3'b010;
    localparam logic [2:0] ULA_SLT = 3'b011;
    localparam logic [2:0] ULA_SLL = 3'b100;
    localparam logic [2:0] ULA_SRL = 3'b101;

    typedef enum logic [2:0] {
        MUL_IDLE = 3'd0,
        MUL_ADD  = 3'd1,
        MUL_SHL  = 3'd2,
        MUL_SHR  = 3'd3,
        MUL_DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/ula.sv
// Combinational WIDTH-bit ula: add, sub, or, signed set-less-than and logical shifts.
// Unselected op codes return the fixed pattern 'h1111.
module ula
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = WIDTH'('h1111);
        case (op)
            ULA_ADD: y = a + b;
            ULA_SUB: y = a - b;
            ULA_OR:  y = a | b;
            ULA_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ULA_SLL: y = a << b;
            ULA_SRL: y = a >> b;
            default: y = WIDTH'('h1111);
        endcase
    end

endmodule

// File: rtl/ula_mul_seq.sv
// Shift-and-add unsigned multiplier that reuses one ula, one operation per cycle.
// Optional ULA_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       ula_op;
    logic [WIDTH-1:0] ula_a;
    logic [WIDTH-1:0] ula_b;
    logic [WIDTH-1:0] ula_y;
    logic             last_iter;

    ula #(.WIDTH(WIDTH)) u_ula (
        .op (ula_op),
        .a  (ula_a),
        .b  (ula_b),
        .y  (ula_y)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ula_op    = ULA_ADD;
        ula_a     = '0;
        ula_b     = '0;
        last_iter = 1'b0;

        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL_ADD;
`ifdef ULA_MUL_EARLY_EXIT_EN
                    if (b == '0) begin
                        state_d   = MUL_DONE;
                        product_d = '0;
                    end
`endif
                end
            end
            MUL_ADD: begin
                // The add slot is spent even when the bit is 0 so latency stays operand-independent.
                ula_op = ULA_ADD;
                ula_a  = acc_q;
                ula_b  = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = ula_y;
                end
                state_d = MUL_SHL;
            end
            MUL_SHL: begin
                ula_op  = ULA_SLL;
                ula_a   = mcand_q;
                ula_b   = WIDTH'(1);
                mcand_d = ula_y;
                state_d = MUL_SHR;
            end
            MUL_SHR: begin
                ula_op    = ULA_SRL;
                ula_a     = mplier_q;
                ula_b     = WIDTH'(1);
                mplier_d  = ula_y;
                cnt_d     = cnt_q + CNT_W'(1);
                last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef ULA_MUL_EARLY_EXIT_EN
                last_iter = last_iter || (ula_y == '0);
`endif
                // acc is final here, so product is loaded on entry to DONE and is valid with done.
                if (last_iter) begin
                    product_d = acc_q;
                    state_d   = MUL_DONE;
                end else begin
                    state_d = MUL_ADD;
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= MUL_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != MUL_IDLE);
    assign done    = (state_q == MUL_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_ula_mul_seq.sv
// Directed testbench for ula_mul_seq: latency, wrap, zero operand, ignored starts, abort.
module tb_ula_mul_seq;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    ula_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle n = the cycle following edge k+n-1, where edge k samples start.
    function automatic int exp_lat(input logic [15:0] mb);
`ifdef ULA_MUL_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 16; i++) if (mb[i]) msb = i;
        if (msb < 0) return 1;
        return 3 * (msb + 1) + 1;
`else
        return 49;
`endif
    endfunction

    // Starts one multiply and observes outputs at each falling edge.
    task automatic run_mul(input logic [15:0] ia, input logic [15:0] ib,
                           input int inj_cyc, input bit inj_done, input int tail,
                           output int done_cyc, output int done_cnt,
                           output int busy_cnt, output logic [15:0] prod);
        @(negedge clock);
        a = ia; b = ib; start = 1'b1;
        @(posedge clock);
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; prod = 16'hxxxx;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    prod = product;
                end
                if (inj_done) begin a = 16'd7; b = 16'd7; start = 1'b1; end
            end
            if (c == inj_cyc) begin a = 16'd7; b = 16'd7; start = 1'b1; end
            if (done_cyc >= 0 && c >= done_cyc + tail) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== 16'h0) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int dc, dn, bc; logic [15:0] p;
        run_mul(16'd3, 16'd4, -1, 1'b0, 1, dc, dn, bc, p);
        checks++; if (dc !== exp_lat(16'd4)) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", dc, exp_lat(16'd4)); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dn); end
        checks++; if (p !== 16'd12) begin errors++; $display("FAIL basic_product got=%h exp=000c", p); end
        checks++; if (bc !== exp_lat(16'd4)) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, exp_lat(16'd4)); end
    endtask

    task automatic test_wrap();
        int dc, dn, bc; logic [15:0] p;
        run_mul(16'hFFFF, 16'hFFFF, -1, 1'b0, 1, dc, dn, bc, p);
        checks++; if (p !== 16'h0001) begin errors++; $display("FAIL wrap_product got=%h exp=0001", p); end
        checks++; if (dc !== exp_lat(16'hFFFF)) begin errors++; $display("FAIL wrap_latency got=%0d exp=%0d", dc, exp_lat(16'hFFFF)); end
    endtask

    task automatic test_zero();
        int dc, dn, bc; logic [15:0] p;
        run_mul(16'h1234, 16'h0000, -1, 1'b0, 1, dc, dn, bc, p);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_product got=%h exp=0000", p); end
        checks++; if (dc !== exp_lat(16'h0)) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", dc, exp_lat(16'h0)); end
    endtask

    task automatic test_back_to_back_ignored();
        int dc, dn, bc; logic [15:0] p;
        run_mul(16'd5, 16'd6, 10, 1'b1, 60, dc, dn, bc, p);
        checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dn); end
        checks++; if (p !== 16'd30) begin errors++; $display("FAIL ignore_product got=%h exp=001e", p); end
        checks++; if (bc !== exp_lat(16'd6)) begin errors++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", bc, exp_lat(16'd6)); end
    endtask

    task automatic test_abort();
        int dc, dn, bc, late_done; logic [15:0] p;
        @(negedge clock);
        a = 16'd9; b = 16'd9; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (product !== 16'h0) begin errors++; $display("FAIL abort_product got=%h exp=0000", product); end
        late_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (done) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", late_done); end
        run_mul(16'd9, 16'd9, -1, 1'b0, 1, dc, dn, bc, p);
        checks++; if (p !== 16'd81) begin errors++; $display("FAIL abort_restart_product got=%h exp=0051", p); end
    endtask

    task automatic test_small_multiplier();
        int dc, dn, bc; logic [15:0] p;
        run_mul(16'd10, 16'd2, -1, 1'b0, 1, dc, dn, bc, p);
        checks++; if (p !== 16'd20) begin errors++; $display("FAIL small_product got=%h exp=0014", p); end
        checks++; if (dc !== exp_lat(16'd2)) begin errors++; $display("FAIL small_latency got=%0d exp=%0d", dc, exp_lat(16'd2)); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_back_to_back_ignored();
        test_abort();
        test_small_multiplier();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
